// File: rtl/tt_fpga_io_bank.sv
// Bidirectional pad bank: synchronised and glitch-filtered inputs with edge pulses,
// registered outputs, and a per-pin direction-turnaround guard against bus contention.
module tt_fpga_io_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TURN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    input  logic [WIDTH-1:0] core_out,
    input  logic [WIDTH-1:0] core_oe,
    output logic [WIDTH-1:0] core_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    typedef enum logic {
        IDLE = 1'b0,
        TURN = 1'b1
    } turn_state_e;

    localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN > 0 ? FILTER_LEN - 1 : 0);
    localparam logic [2:0] TURN_LAST = 3'(TURN_CYCLES > 0 ? TURN_CYCLES - 1 : 0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) pad_out <= '0;
        else     pad_out <= core_out;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic                   in_q, in_d, rise_q, fall_q;
        logic [3:0]             cnt_q, cnt_d;

        assign s = sync_q[SYNC_STAGES-1];

        // NOTE: every always_comb output gets a default first so no latch is inferred.
        always_comb begin
            in_d  = in_q;
            cnt_d = '0;
            if (FILTER_LEN == 0) begin
                in_d = s;
            end else if (s != in_q) begin
                if (cnt_q == FILT_LAST) in_d  = s;
                else                    cnt_d = cnt_q + 4'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
                in_q   <= 1'b0;
                cnt_q  <= '0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in[i]};
                in_q   <= in_d;
                cnt_q  <= cnt_d;
                rise_q <= ~in_q & in_d;
                fall_q <= in_q & ~in_d;
            end
        end

        assign core_in[i] = in_q;
        assign rise[i]    = rise_q;
        assign fall[i]    = fall_q;

        turn_state_e state_q, state_d;
        logic        dir_q, dir_d, tgt_q, tgt_d, oe_q;
        logic [2:0]  tc_q, tc_d;

        always_comb begin
            state_d = state_q;
            dir_d   = dir_q;
            tgt_d   = tgt_q;
            tc_d    = tc_q;
            if (!ena) begin
                state_d = IDLE;
                dir_d   = 1'b0;
                tgt_d   = 1'b0;
                tc_d    = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (core_oe[i] != dir_q) begin
                            if (TURN_CYCLES == 0) begin
                                dir_d = core_oe[i];
                            end else begin
                                tgt_d   = core_oe[i];
                                tc_d    = '0;
                                state_d = TURN;
                            end
                        end
                    end
                    TURN: begin
                        // A new request while turning restarts the quiet period.
                        if (core_oe[i] != tgt_q) begin
                            tgt_d = core_oe[i];
                            tc_d  = '0;
                        end else if (tc_q == TURN_LAST) begin
                            dir_d   = tgt_q;
                            tc_d    = '0;
                            state_d = IDLE;
                        end else begin
                            tc_d = tc_q + 3'd1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                dir_q   <= 1'b0;
                tgt_q   <= 1'b0;
                tc_q    <= '0;
                oe_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                dir_q   <= dir_d;
                tgt_q   <= tgt_d;
                tc_q    <= tc_d;
                oe_q    <= (state_d == IDLE) ? dir_d : 1'b0;
            end
        end

        assign pad_oe[i] = oe_q;
    end

endmodule

// File: tb/tb_tt_fpga_io_bank.sv
// Bench for tt_fpga_io_bank: two parameterisations driven together, directed steps
// followed by random traffic, all compared against an event-level reference model.
module tb_tt_fpga_io_bank;

    localparam int W    = 8;
    localparam int SS   = 2;
    localparam int FL_A = 4;
    localparam int TC_A = 1;
    localparam int FL_B = 0;
    localparam int TC_B = 3;

    logic         clk = 1'b0;
    logic         rst, ena;
    logic [W-1:0] pad_in, core_out, core_oe;
    logic [W-1:0] pout_a, oe_a, ci_a, rise_a, fall_a;
    logic [W-1:0] pout_b, oe_b, ci_b, rise_b, fall_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tt_fpga_io_bank #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(FL_A), .TURN_CYCLES(TC_A)) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .pad_in(pad_in), .pad_out(pout_a), .pad_oe(oe_a),
        .core_out(core_out), .core_oe(core_oe), .core_in(ci_a), .rise(rise_a), .fall(fall_a)
    );

    tt_fpga_io_bank #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(FL_B), .TURN_CYCLES(TC_B)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .pad_in(pad_in), .pad_out(pout_b), .pad_oe(oe_b),
        .core_out(core_out), .core_oe(core_oe), .core_in(ci_b), .rise(rise_b), .fall(fall_b)
    );

    // Reference model: histories of pad and synchronised values, and per-pin turnaround deadlines.
    logic [W-1:0] pad_hist[$];
    logic [W-1:0] s_hist[$];
    logic [W-1:0] m_cin[2], m_rise[2], m_fall[2], m_oe[2];
    logic [W-1:0] m_pout;
    logic         m_dir[2][W], m_busy[2][W], m_tgt[2][W];
    int           m_end[2][W];
    int           edge_n = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] s, nxt;
        int           fl, tc;
        bit           all_diff;
        edge_n++;
        if (rst) begin
            pad_hist.delete();
            s_hist.delete();
            m_pout = '0;
            for (int k = 0; k < 2; k++) begin
                m_cin[k] = '0; m_rise[k] = '0; m_fall[k] = '0; m_oe[k] = '0;
                for (int i = 0; i < W; i++) begin
                    m_dir[k][i] = 1'b0; m_busy[k][i] = 1'b0; m_tgt[k][i] = 1'b0; m_end[k][i] = 0;
                end
            end
            return;
        end
        // s seen at this edge is the pad value captured SS edges earlier.
        s = (pad_hist.size() >= SS) ? pad_hist[SS-1] : '0;
        pad_hist.push_front(pad_in);
        if (pad_hist.size() > SS) void'(pad_hist.pop_back());
        s_hist.push_front(s);
        if (s_hist.size() > 16) void'(s_hist.pop_back());
        m_pout = core_out;
        for (int k = 0; k < 2; k++) begin
            fl  = (k == 0) ? FL_A : FL_B;
            tc  = (k == 0) ? TC_A : TC_B;
            nxt = m_cin[k];
            for (int i = 0; i < W; i++) begin
                if (fl == 0) begin
                    nxt[i] = s[i];
                end else if (s_hist.size() >= fl) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < fl; j++)
                        if (s_hist[j][i] == m_cin[k][i]) all_diff = 1'b0;
                    if (all_diff) nxt[i] = s[i];
                end
                if (!ena) begin
                    m_dir[k][i]  = 1'b0;
                    m_busy[k][i] = 1'b0;
                end else if (!m_busy[k][i]) begin
                    if (core_oe[i] != m_dir[k][i]) begin
                        if (tc == 0) begin
                            m_dir[k][i] = core_oe[i];
                        end else begin
                            m_busy[k][i] = 1'b1;
                            m_tgt[k][i]  = core_oe[i];
                            m_end[k][i]  = edge_n + tc;
                        end
                    end
                end else if (core_oe[i] != m_tgt[k][i]) begin
                    m_tgt[k][i] = core_oe[i];
                    m_end[k][i] = edge_n + tc;
                end else if (edge_n >= m_end[k][i]) begin
                    m_dir[k][i]  = m_tgt[k][i];
                    m_busy[k][i] = 1'b0;
                end
                m_oe[k][i] = m_busy[k][i] ? 1'b0 : m_dir[k][i];
            end
            m_rise[k] = ~m_cin[k] & nxt;
            m_fall[k] = m_cin[k] & ~nxt;
            m_cin[k]  = nxt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("a_pad_out", pout_a, m_pout);
        check("a_pad_oe",  oe_a,   m_oe[0]);
        check("a_core_in", ci_a,   m_cin[0]);
        check("a_rise",    rise_a, m_rise[0]);
        check("a_fall",    fall_a, m_fall[0]);
        check("b_pad_out", pout_b, m_pout);
        check("b_pad_oe",  oe_b,   m_oe[1]);
        check("b_core_in", ci_b,   m_cin[1]);
        check("b_rise",    rise_b, m_rise[1]);
        check("b_fall",    fall_b, m_fall[1]);
    endtask

    initial begin
        int n_a, n_b, n_c;

        // Reset held with pads high and all pins requesting drive.
        rst = 1'b1; ena = 1'b1; pad_in = 8'hFF; core_oe = 8'hFF; core_out = 8'h00;
        repeat (3) begin
            tick();
            check("rst_pad_oe",  oe_a | oe_b, 8'h00);
            check("rst_core_in", ci_a | ci_b, 8'h00);
            check("rst_pulses",  rise_a | fall_a | rise_b | fall_b, 8'h00);
        end
        rst = 1'b0;
        tick(); check("rel_oe_a_e1", oe_a, 8'h00);
        tick(); check("rel_oe_a_e2", oe_a, 8'hFF); check("rel_oe_b_e2", oe_b, 8'h00);
        tick(); check("rel_oe_b_e3", oe_b, 8'h00);
        tick(); check("rel_oe_b_e4", oe_b, 8'hFF);
        pad_in = 8'h00;
        repeat (12) tick();

        // Filter latency: one rise pulse, then one fall pulse.
        pad_in[0] = 1'b1;
        n_a = 0;
        repeat (15) begin tick(); n_a += int'(rise_a[0]); end
        check("filt_rise_cnt", W'(n_a), 8'd1);
        check("filt_cin_hi",   W'(ci_a[0]), 8'd1);
        pad_in[0] = 1'b0;
        n_a = 0;
        repeat (15) begin tick(); n_a += int'(fall_a[0]); end
        check("filt_fall_cnt", W'(n_a), 8'd1);

        // Glitch of 3 cycles: rejected by the filter, passed when the filter is off.
        n_a = 0; n_b = 0; n_c = 0;
        pad_in[3] = 1'b1;
        repeat (3) begin tick(); n_a += int'(ci_a[3]); n_b += int'(ci_b[3]); n_c += int'(rise_a[3]); end
        pad_in[3] = 1'b0;
        repeat (12) begin tick(); n_a += int'(ci_a[3]); n_b += int'(ci_b[3]); n_c += int'(rise_a[3]); end
        check("glitch_cin_a",  W'(n_a), 8'd0);
        check("glitch_rise_a", W'(n_c), 8'd0);
        check("glitch_cin_b",  W'(n_b), 8'd3);

        // Turnaround on pin 5 of the TURN_CYCLES=3 instance.
        core_oe[5] = 1'b0;
        tick(); check("turn_drop", W'(oe_b[5]), 8'd0);
        repeat (5) tick();
        core_oe[5] = 1'b1;
        repeat (3) begin tick(); check("turn_wait", W'(oe_b[5]), 8'd0); end
        tick(); check("turn_done", W'(oe_b[5]), 8'd1);
        core_oe[5] = 1'b0;
        repeat (2) tick();
        core_oe[5] = 1'b1;
        repeat (3) begin tick(); check("turn_restart_wait", W'(oe_b[5]), 8'd0); end
        tick(); check("turn_restart_done", W'(oe_b[5]), 8'd1);

        // Enable dropped with pin 2 mid-turnaround.
        core_oe[2] = 1'b0;
        tick();
        ena = 1'b0; core_out = 8'h5A; pad_in = 8'hC3;
        tick();
        check("ena_oe_a", oe_a, 8'h00);
        check("ena_oe_b", oe_b, 8'h00);
        check("ena_pout", pout_a, 8'h5A);
        repeat (10) tick();
        check("ena_cin", ci_a, 8'hC3);
        ena = 1'b1;

        // Read-back: pin 7 drives and its pad value loops back into core_in.
        core_oe = 8'h80; core_out = 8'h80; pad_in = 8'h00;
        repeat (12) begin tick(); pad_in = {pout_a[7], 7'h00}; end
        check("readback_a", ci_a, 8'h80);
        check("readback_b", ci_b, 8'h80);

        // Random traffic, including occasional enable drops and mid-operation resets.
        for (int n = 0; n < 600; n++) begin
            pad_in   = pad_in ^ (W'($urandom) & W'($urandom) & W'($urandom));
            if ($urandom_range(0, 3) == 0) core_oe = core_oe ^ (W'($urandom) & W'($urandom));
            core_out = W'($urandom);
            ena      = ($urandom_range(0, 19) != 0);
            rst      = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
